// File: rtl/t_xor_accum_if.sv
// t_xor_accum_if: input-word and checksum-output handshake bundle for t_xor_accum.
interface t_xor_accum_if #(
  parameter int TRITS = 4,
  parameter int CNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [2*TRITS-1:0] in_data;
  logic               in_mode;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [2*TRITS-1:0] out_data;
  logic [CNT_W-1:0]   out_count;
  logic               out_err;
  modport master (
    output in_valid, in_data, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_err
  );
  modport slave (
    input  in_valid, in_data, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_err
  );
endinterface

// File: rtl/t_xor_accum.sv
// t_xor_accum: ternary trit-wise add/subtract mod 3 frame accumulator with counter and handshakes.
// Defining T_XOR_INVALID_CHK_EN builds the sticky invalid-trit (2'b11) frame error flag.
module t_xor_accum #(
  parameter int TRITS = 4,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  t_xor_accum_if.slave  bus
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t             state_q, state_d;
  logic [2*TRITS-1:0] acc_q, acc_d, data_q, data_d, sum;
  logic [CNT_W-1:0]   cnt_q, cnt_d, count_q, count_d, cnt_inc;
  logic               accept, fin;
  // invalid code decodes as 0; subtraction adds the mod-3 negation
  function automatic logic [1:0] trit_op(input logic [1:0] a, input logic [1:0] b, input logic sub);
    logic [1:0] bb, nb;
    logic [2:0] s;
    bb = (b == 2'b11) ? 2'd0 : b;
    nb = (sub && bb != 2'd0) ? 2'd3 - bb : bb;
    s = {1'b0, a} + {1'b0, nb};
    s = (s >= 3'd3) ? s - 3'd3 : s;
    return s[1:0];
  endfunction
  for (genvar i = 0; i < TRITS; i++) begin : g_trit
    assign sum[2*i+1:2*i] = trit_op(acc_q[2*i+1:2*i], bus.in_data[2*i+1:2*i], bus.in_mode);
  end
  assign accept  = bus.in_valid && state_q == ACCUM;
  assign fin     = accept && bus.in_last;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
  always_comb begin
    state_d = fin ? HOLD : (state_q == HOLD && bus.out_ready) ? ACCUM : state_q;
    acc_d   = accept ? (bus.in_last ? '0 : sum) : acc_q;
    cnt_d   = accept ? (bus.in_last ? '0 : cnt_inc) : cnt_q;
    data_d  = fin ? sum : data_q;
    count_d = fin ? cnt_inc : count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end
  assign bus.in_ready  = state_q == ACCUM;
  assign bus.out_valid = state_q == HOLD;
  assign bus.out_data  = data_q;
  assign bus.out_count = count_q;
`ifdef T_XOR_INVALID_CHK_EN
  logic bad, ferr_q, ferr_d, err_q, err_d;
  always_comb begin
    bad = 1'b0;
    for (int k = 0; k < TRITS; k++) bad = bad | (&bus.in_data[2*k+:2]);
    ferr_d = accept ? (bus.in_last ? 1'b0 : ferr_q | bad) : ferr_q;
    err_d  = fin ? ferr_q | bad : err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ferr_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ferr_q <= ferr_d;
      err_q  <= err_d;
    end
  end
  assign bus.out_err = err_q;
`else
  assign bus.out_err = 1'b0;
`endif
endmodule

// File: tb/tb_t_xor_accum.sv
// tb_t_xor_accum: table-driven directed bench for t_xor_accum (CNT_W=8 main instance, CNT_W=2 saturation instance).
module tb_t_xor_accum;
`ifdef T_XOR_INVALID_CHK_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  typedef struct {
    logic [7:0] d;
    logic       m;
    logic       l;
    logic [7:0] exp;
    logic [7:0] cnt;
    logic       err;
  } vec_t;
  logic clk = 0, rst_n = 0, v = 0, m = 0, l = 0, ordy = 0, sel = 0;
  logic [7:0] d = '0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  t_xor_accum_if #(.TRITS(4), .CNT_W(8)) b();
  t_xor_accum_if #(.TRITS(4), .CNT_W(2)) b2();
  assign b.in_valid  = v & ~sel;
  assign b.in_data   = d;
  assign b.in_mode   = m;
  assign b.in_last   = l;
  assign b.out_ready = ordy & ~sel;
  assign b2.in_valid  = v & sel;
  assign b2.in_data   = d;
  assign b2.in_mode   = m;
  assign b2.in_last   = l;
  assign b2.out_ready = ordy & sel;
  t_xor_accum #(.TRITS(4), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  t_xor_accum #(.TRITS(4), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  wire       rdy   = sel ? b2.in_ready : b.in_ready;
  wire       ovld  = sel ? b2.out_valid : b.out_valid;
  wire [7:0] odata = sel ? b2.out_data : b.out_data;
  wire [7:0] ocnt  = sel ? {6'b0, b2.out_count} : b.out_count;
  wire       oerr  = sel ? b2.out_err : b.out_err;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic send(input logic [7:0] dd, input logic mm, input logic ll);
    int n = 0;
    v = 1; d = dd; m = mm; l = ll;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 8'd1, 8'd0);
    @(negedge clk);
    v = 0; l = 0;
    if (ll) chk("latency_out_valid", {7'b0, ovld}, 8'd1);
  endtask
  task automatic take();
    ordy = 1;
    @(negedge clk);
    ordy = 0;
    chk("take_out_valid", {7'b0, ovld}, 8'd0);
    chk("take_in_ready", {7'b0, rdy}, 8'd1);
  endtask
  vec_t vt[11];
  logic [7:0] held;
  initial begin
    vt[0]  = '{8'h55, 1'b0, 1'b1, 8'h55, 8'd1, 1'b0};
    vt[1]  = '{8'h19, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0};
    vt[2]  = '{8'hA4, 1'b0, 1'b1, 8'h81, 8'd2, 1'b0};
    vt[3]  = '{8'h55, 1'b1, 1'b1, 8'hAA, 8'd1, 1'b0};
    vt[4]  = '{8'h80, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0};
    vt[5]  = '{8'h40, 1'b1, 1'b1, 8'h40, 8'd2, 1'b0};
    vt[6]  = '{8'hC1, 1'b0, 1'b1, 8'h01, 8'd1, ERR};
    vt[7]  = '{8'h02, 1'b0, 1'b1, 8'h02, 8'd1, 1'b0};
    vt[8]  = '{8'hAA, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0};
    vt[9]  = '{8'hAA, 1'b0, 1'b0, 8'h00, 8'd0, 1'b0};
    vt[10] = '{8'h4B, 1'b1, 1'b1, 8'h19, 8'd3, ERR};
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {7'b0, rdy}, 8'd1);
    chk("rst_out_valid", {7'b0, ovld}, 8'd0);
    chk("rst_out_data", odata, 8'h00);
    chk("rst_out_count", ocnt, 8'd0);
    chk("rst_out_err", {7'b0, oerr}, 8'd0);
    rst_n = 1;
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      send(vt[i].d, vt[i].m, vt[i].l);
      if (vt[i].l) begin
        chk($sformatf("vec%0d_data", i), odata, vt[i].exp);
        chk($sformatf("vec%0d_count", i), ocnt, vt[i].cnt);
        chk($sformatf("vec%0d_err", i), {7'b0, oerr}, {7'b0, vt[i].err});
        take();
      end
    end
    send(8'h19, 1'b0, 1'b1);
    held = odata;
    v = 1; d = 8'hAA; m = 0; l = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {7'b0, rdy}, 8'd0);
      chk("bp_out_valid", {7'b0, ovld}, 8'd1);
      chk("bp_out_data", odata, held);
    end
    v = 0;
    take();
    send(8'h01, 1'b0, 1'b1);
    chk("bp_after_data", odata, 8'h01);
    chk("bp_after_count", ocnt, 8'd1);
    take();
    send(8'h55, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", {7'b0, ovld}, 8'd0);
    chk("midrst_in_ready", {7'b0, rdy}, 8'd1);
    chk("midrst_out_count", ocnt, 8'd0);
    @(negedge clk);
    rst_n = 1;
    send(8'h55, 1'b0, 1'b1);
    chk("midrst_frame_data", odata, 8'h55);
    chk("midrst_frame_count", ocnt, 8'd1);
    rst_n = 0;
    #1;
    chk("holdrst_out_valid", {7'b0, ovld}, 8'd0);
    chk("holdrst_out_data", odata, 8'h00);
    @(negedge clk);
    rst_n = 1;
    sel = 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) send(8'h01, 1'b0, i == 5);
    chk("sat_count", ocnt, 8'd3);
    chk("sat_data", odata, 8'h00);
    take();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
